video_frame_gen: RTL and testbench
==================================

VIDEO_FRAME_GEN -- requirements
Module: video_frame_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters COL_MIN/COL_MAX, defaults 208/432, half-open window column bounds in screen pixels.
REQ-006 SHALL have parameters ROW_MIN/ROW_MAX, defaults 96/384, half-open window row bounds in screen lines.
REQ-007 SHALL have parameter PIX_LAT, default 2, range 1..8, pixel-source latency in pixel ticks.
REQ-008 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-009 SHALL have port clk, input, 1, single system clock.
REQ-010 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-011 SHALL have port pix_en, input, 1, pixel-tick enable; all timing advances only on cycles where pix_en=1.
REQ-012 SHALL have port border_color, input, 3*COLOR_W, {R,G,B} driven inside active area but outside window.
REQ-013 SHALL have ports pix_r/pix_g/pix_b, input, COLOR_W each, pixel-source colour returned PIX_LAT ticks after request.
REQ-014 SHALL have ports pix_req (output, 1), off_col (output, 10), off_row (output, 9): window-relative pixel request.
REQ-015 SHALL have ports vgaRed/vgaGreen/vgaBlue (output, COLOR_W each), Hsync/Vsync (output, 1, active low).
REQ-016 SHALL have ports blank (output, 1), vblank_start (output, 1), frame_cnt (output, 16).

Function
REQ-017 SHALL keep col counter 0..H_total-1 and row counter 0..V_total-1, with H_total = sum of H parameters and V_total = sum of V parameters; col wraps to 0 and row increments on the tick where col=H_total-1; row wraps to 0 after V_total-1.
REQ-018 SHALL assert raw hsync (low) for H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC and raw vsync (low) analogously on row.
REQ-019 SHALL assert raw blank when col>=H_ACTIVE or row>=V_ACTIVE.
REQ-020 SHALL assert pix_req combinationally from the counters when ROW_MIN<=row<ROW_MAX and COL_MIN<=col<COL_MAX; off_col=col-COL_MIN, off_row=row-ROW_MIN, truncated to port width; off_col/off_row are don't-care when pix_req=0.
REQ-021 SHALL delay raw hsync, vsync, blank and in-window through a PIX_LAT-stage shift register advanced only on pix_en.
REQ-022 SHALL register outputs on pix_en: delayed blank -> colours 0; else delayed in-window -> pix_r/g/b; else border_color.
REQ-023 SHALL drive Hsync, Vsync and blank from the delayed stage, registered with the colours, so all five are aligned.
REQ-024 SHALL pulse vblank_start for exactly one clk cycle on the pix_en tick where the counters enter row=V_ACTIVE, col=0.
REQ-025 SHALL increment frame_cnt (wrapping at 2^16) in the same cycle as vblank_start.
REQ-026 SHALL hold all state when pix_en=0; a pix_en that is held high continuously SHALL give one pixel per clk.
REQ-027 SHALL sample border_color only on pix_en ticks; mid-frame changes SHALL take effect on the next output pixel.

Reset
REQ-028 SHALL, while rst=1, force col=0, row=0, all shift-register stages to blank=1, in-window=0, hsync/vsync inactive, Hsync=1, Vsync=1, blank=1, colours 0, vblank_start=0, frame_cnt=0.
REQ-029 SHALL, on rst deassertion mid-frame, restart at col=0,row=0 with no vblank_start until row V_ACTIVE is reached.

Configuration
REQ-030 SHALL, when macro VIDEO_SCALE2X_EN is defined, output off_col=(col-COL_MIN)>>1 and off_row=(row-ROW_MIN)>>1 (each source pixel covers 2x2 screen pixels); pix_req and window bounds are unchanged.
REQ-031 SHALL, without VIDEO_SCALE2X_EN, produce unscaled offsets per REQ-020.

Verification
REQ-032 SHALL verify reset: assert rst -> Hsync=1, Vsync=1, blank=1, colours 0, frame_cnt=0.
REQ-033 SHALL verify sync timing with defaults and pix_en every 4th clk: Hsync low for 96 ticks starting at tick col 656+PIX_LAT+1; Vsync low for 2 lines at rows 490-491.
REQ-034 SHALL verify window edges: row 96, col 208 -> pix_req=1, off_col=0, off_row=0; col 431 -> off_col=223; col 432 -> pix_req=0.
REQ-035 SHALL verify colour muxing: border_color=12'hF00, pix=4'h5 -> pixel (100,50) outputs R=F,G=0,B=0; pixel (300,200) outputs 5/5/5; col 700 outputs 0.
REQ-036 SHALL verify frame end: at row 480, col 0 -> single-cycle vblank_start, frame_cnt 0->1; after 65536 frames (forced counter) -> wraps to 0.
REQ-037 SHALL verify VIDEO_SCALE2X_EN: cols 208/209/210 -> off_col 0/0/1; rows 96/97/98 -> off_row 0/0/1.

Source files
------------

// File: rtl/video_frame_gen.sv
// Raster timing generator with a windowed pixel-source request and latency-aligned outputs.
// Define VIDEO_SCALE2X_EN to halve window offsets (each source pixel covers 2x2 screen pixels).
module video_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COL_MIN  = 208,
    parameter int COL_MAX  = 432,
    parameter int ROW_MIN  = 96,
    parameter int ROW_MAX  = 384,
    parameter int PIX_LAT  = 2,
    parameter int COLOR_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_en,
    input  logic [3*COLOR_W-1:0]   border_color,
    input  logic [COLOR_W-1:0]     pix_r,
    input  logic [COLOR_W-1:0]     pix_g,
    input  logic [COLOR_W-1:0]     pix_b,
    output logic                   pix_req,
    output logic [9:0]             off_col,
    output logic [8:0]             off_row,
    output logic [COLOR_W-1:0]     vgaRed,
    output logic [COLOR_W-1:0]     vgaGreen,
    output logic [COLOR_W-1:0]     vgaBlue,
    output logic                   Hsync,
    output logic                   Vsync,
    output logic                   blank,
    output logic                   vblank_start,
    output logic [15:0]            frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW = $clog2(H_TOTAL + 1);
    localparam int RW = $clog2(V_TOTAL + 1);

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] CMIN_C  = CW'(COL_MIN);
    localparam logic [CW-1:0] CMAX_C  = CW'(COL_MAX);

    localparam logic [RW-1:0] V_LAST  = RW'(V_TOTAL - 1);
    localparam logic [RW-1:0] V_ACT_C = RW'(V_ACTIVE);
    localparam logic [RW-1:0] V_PRE   = RW'(V_ACTIVE - 1);
    localparam logic [RW-1:0] VS_BEG  = RW'(V_ACTIVE + V_FP);
    localparam logic [RW-1:0] VS_END  = RW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [RW-1:0] RMIN_C  = RW'(ROW_MIN);
    localparam logic [RW-1:0] RMAX_C  = RW'(ROW_MAX);

    // One delay-line tap; hs/vs are active-high here and inverted at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic bl;
        logic win;
    } tap_t;

    localparam tap_t TAP_RST = '{hs: 1'b0, vs: 1'b0, bl: 1'b1, win: 1'b0};

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          hs_raw;
    logic          vs_raw;
    logic          bl_raw;
    logic          win_raw;
    logic [CW-1:0] dcol;
    logic [RW-1:0] drow;
    tap_t          pipe [PIX_LAT];
    tap_t          tap_out;

    assign col_last = (col == H_LAST);
    assign row_last = (row == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign hs_raw  = (col >= HS_BEG) && (col < HS_END);
    assign vs_raw  = (row >= VS_BEG) && (row < VS_END);
    assign bl_raw  = (col >= H_ACT_C) || (row >= V_ACT_C);
    assign win_raw = (row >= RMIN_C) && (row < RMAX_C) &&
                     (col >= CMIN_C) && (col < CMAX_C);

    assign pix_req = win_raw;
    assign dcol    = col - CMIN_C;
    assign drow    = row - RMIN_C;

`ifdef VIDEO_SCALE2X_EN
    assign off_col = 10'(dcol >> 1);
    assign off_row = 9'(drow >> 1);
`else
    assign off_col = 10'(dcol);
    assign off_row = 9'(drow);
`endif

    // Timing flags travel alongside the pixel-source latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                pipe[i] <= TAP_RST;
            end
        end else if (pix_en) begin
            pipe[0] <= '{hs: hs_raw, vs: vs_raw, bl: bl_raw, win: win_raw};
            for (int i = 1; i < PIX_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tap_out = pipe[PIX_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Hsync    <= 1'b1;
            Vsync    <= 1'b1;
            blank    <= 1'b1;
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
        end else if (pix_en) begin
            Hsync <= ~tap_out.hs;
            Vsync <= ~tap_out.vs;
            blank <= tap_out.bl;
            if (tap_out.bl) begin
                {vgaRed, vgaGreen, vgaBlue} <= '0;
            end else if (tap_out.win) begin
                {vgaRed, vgaGreen, vgaBlue} <= {pix_r, pix_g, pix_b};
            end else begin
                {vgaRed, vgaGreen, vgaBlue} <= border_color;
            end
        end
    end

    // Pulse lasts one clk even when pix_en ticks are sparse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_start <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            vblank_start <= 1'b0;
            if (pix_en && col_last && (row == V_PRE)) begin
                vblank_start <= 1'b1;
                frame_cnt    <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_frame_gen.sv
// Directed bench for video_frame_gen: default horizontal timing, shortened vertical timing.
// Honors VIDEO_SCALE2X_EN for expected window offsets.
module tb_video_frame_gen;

    localparam int PL = 2;
    localparam int HT = 800;
    localparam int VT = 19;
    localparam int FR = HT * VT;
    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [11:0] border_color;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic        pix_req;
    logic [9:0]  off_col;
    logic [8:0]  off_row;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;
    logic        Hsync, Vsync, blank, vblank_start;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int tk = 0;
    int vb_cnt = 0;
    int vb_tk = -1;

    always #5 clk = ~clk;

    video_frame_gen #(
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .ROW_MIN(3), .ROW_MAX(9), .PIX_LAT(PL)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .border_color(border_color),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_req(pix_req), .off_col(off_col), .off_row(off_row),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .Hsync(Hsync), .Vsync(Vsync), .blank(blank),
        .vblank_start(vblank_start), .frame_cnt(frame_cnt)
    );

    always @(negedge clk) begin
        if (vblank_start === 1'b1) begin
            vb_cnt++;
            vb_tk = tk;
        end
    end

    typedef struct {
        int          row;
        int          col;
        logic [11:0] bord;
        logic        req;
        int          dc;
        int          dr;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } vec_t;

    vec_t tbl [NV];

    function automatic int sc(input int d);
`ifdef VIDEO_SCALE2X_EN
        return d >> 1;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int gap);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        tk++;
    endtask

    task automatic advance_to(input int t);
        while (tk < t) step(0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hsync"}, 32'(Hsync), 1);
        chk({tag, "_vsync"}, 32'(Vsync), 1);
        chk({tag, "_blank"}, 32'(blank), 1);
        chk({tag, "_rgb"}, 32'({vgaRed, vgaGreen, vgaBlue}), 0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
        chk({tag, "_vbs"}, 32'(vblank_start), 0);
    endtask

    initial begin
        int first_lo;
        int lo_cnt;
        int last;
        int p;
        int vb0;

        //          row col  bord     req dc   dr  rgb      Hs Vs bl
        tbl[0]  = '{1,  100, 12'hF00, 0,  0,   0,  12'hF00, 1, 1, 0};
        tbl[1]  = '{2,  300, 12'hF00, 0,  0,   0,  12'hF00, 1, 1, 0};
        tbl[2]  = '{3,  208, 12'hF00, 1,  0,   0,  12'h555, 1, 1, 0};
        tbl[3]  = '{3,  431, 12'hF00, 1,  223, 0,  12'h555, 1, 1, 0};
        tbl[4]  = '{3,  432, 12'h0A5, 0,  0,   0,  12'h0A5, 1, 1, 0};
        tbl[5]  = '{3,  700, 12'h0A5, 0,  0,   0,  12'h000, 0, 1, 1};
        tbl[6]  = '{5,  300, 12'hF00, 1,  92,  2,  12'h555, 1, 1, 0};
        tbl[7]  = '{8,  208, 12'hF00, 1,  0,   5,  12'h555, 1, 1, 0};
        tbl[8]  = '{9,  208, 12'hF00, 0,  0,   0,  12'hF00, 1, 1, 0};
        tbl[9]  = '{11, 639, 12'hF00, 0,  0,   0,  12'hF00, 1, 1, 0};
        tbl[10] = '{11, 640, 12'hF00, 0,  0,   0,  12'h000, 1, 1, 1};
        tbl[11] = '{12, 0,   12'hF00, 0,  0,   0,  12'h000, 1, 1, 1};
        tbl[12] = '{13, 796, 12'hF00, 0,  0,   0,  12'h000, 1, 1, 1};
        tbl[13] = '{14, 0,   12'hF00, 0,  0,   0,  12'h000, 1, 0, 1};
        tbl[14] = '{15, 796, 12'hF00, 0,  0,   0,  12'h000, 1, 0, 1};
        tbl[15] = '{16, 0,   12'hF00, 0,  0,   0,  12'h000, 1, 1, 1};

        rst = 1'b1;
        pix_en = 1'b0;
        border_color = 12'hF00;
        pix_r = 4'h5;
        pix_g = 4'h5;
        pix_b = 4'h5;
        repeat (3) @(posedge clk);
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pix_en = 1'b0;
        chk_reset_outs("rst");
        chk("rst_pixreq", 32'(pix_req), 0);
        rst = 1'b0;

        // Sparse ticks: one pix_en every 4th clk across the first line.
        first_lo = -1;
        lo_cnt = 0;
        while (tk < HT) begin
            step(3);
            if (Hsync === 1'b0) begin
                if (first_lo < 0) first_lo = tk;
                lo_cnt++;
            end
        end
        chk("hsync_start", first_lo, 656 + PL + 1);
        chk("hsync_width", lo_cnt, 96);

        last = 16 * HT + PL + 1;
        while (tk < last) begin
            for (int k = 0; k < NV; k++) begin
                if (tbl[k].row * HT + tbl[k].col + PL + 1 == tk + 1)
                    border_color = tbl[k].bord;
            end
            step(0);
            for (int k = 0; k < NV; k++) begin
                p = tbl[k].row * HT + tbl[k].col;
                if (p == tk) begin
                    chk($sformatf("e%0d_req", k), 32'(pix_req), 32'(tbl[k].req));
                    if (tbl[k].req) begin
                        chk($sformatf("e%0d_offc", k), 32'(off_col), sc(tbl[k].dc));
                        chk($sformatf("e%0d_offr", k), 32'(off_row), sc(tbl[k].dr));
                    end
                end
                if (p + PL + 1 == tk) begin
                    chk($sformatf("e%0d_rgb", k),
                        32'({vgaRed, vgaGreen, vgaBlue}), 32'(tbl[k].rgb));
                    chk($sformatf("e%0d_hs", k), 32'(Hsync), 32'(tbl[k].hs));
                    chk($sformatf("e%0d_vs", k), 32'(Vsync), 32'(tbl[k].vs));
                    chk($sformatf("e%0d_bl", k), 32'(blank), 32'(tbl[k].bl));
                end
            end
        end
        chk("f0_vb_cnt", vb_cnt, 1);
        chk("f0_vb_tick", vb_tk, 12 * HT);
        chk("f0_fcnt", 32'(frame_cnt), 1);

        // Window edge offsets across adjacent columns and rows.
        advance_to(FR + 3 * HT + 208);
        chk("sc_c208_req", 32'(pix_req), 1);
        chk("sc_c208", 32'(off_col), sc(0));
        chk("sc_r96", 32'(off_row), sc(0));
        step(0);
        chk("sc_c209", 32'(off_col), sc(1));
        step(0);
        chk("sc_c210", 32'(off_col), sc(2));
        advance_to(FR + 4 * HT + 208);
        chk("sc_r97", 32'(off_row), sc(1));
        advance_to(FR + 5 * HT + 208);
        chk("sc_r98", 32'(off_row), sc(2));

        // Frame end with sparse ticks: pulse must not stretch.
        advance_to(FR + 12 * HT - 1);
        chk("f1_pre_vbs", 32'(vblank_start), 0);
        chk("f1_pre_fcnt", 32'(frame_cnt), 1);
        step(3);
        chk("f1_vbs", 32'(vblank_start), 1);
        chk("f1_fcnt", 32'(frame_cnt), 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("f1_vbs_drop%0d", i), 32'(vblank_start), 0);
        end
        chk("f1_vb_cnt", vb_cnt, 2);

        // Counter wrap from a forced all-ones value.
        advance_to(2 * FR + 12 * HT - 1);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt;
        chk("wrap_forced", 32'(frame_cnt), 32'hFFFF);
        step(0);
        chk("wrap_vbs", 32'(vblank_start), 1);
        chk("wrap_fcnt", 32'(frame_cnt), 0);

        // Asynchronous reset in the middle of the vertical sync.
        advance_to(2 * FR + 14 * HT + 700);
        chk("pre_rst_hs", 32'(Hsync), 0);
        chk("pre_rst_vs", 32'(Vsync), 0);
        chk("pre_rst_vb_cnt", vb_cnt, 3);
        rst = 1'b1;
        #1;
        chk_reset_outs("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tk = 0;
        vb0 = vb_cnt;
        advance_to(3 * HT + 208);
        chk("rr_req", 32'(pix_req), 1);
        chk("rr_offc", 32'(off_col), 0);
        chk("rr_offr", 32'(off_row), 0);
        advance_to(12 * HT - 1);
        chk("rr_no_vb", vb_cnt, vb0);
        step(0);
        chk("rr_vbs", 32'(vblank_start), 1);
        chk("rr_fcnt", 32'(frame_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
